multicycle_controller_main_fsm: RTL

Sequencing half of the multicycle controller. It consumes the instruction word held in the instruction register and steps the datapath through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK. It drives every enable and mux select that is not a pure field decode. It also owns the NZCV flag register and the condition-code check that gates architectural writes.

---
 rtl/multicycle_controller_main_fsm.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller_main_fsm.sv
// Main sequencing FSM of the multicycle controller. Walks each instruction
// through fetch, decode, execute, memory and writeback. It drives the datapath
// enables and mux selects, and it owns the NZCV flags together with the
// condition check that gates every architectural write.
module multicycle_controller_main_fsm #(
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] INSTRUCTION,
  input  logic [3:0]  ALU_FLAGS,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        AdrSrc,
  output logic [1:0]  ResultSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUControl,
  output logic        ILLEGAL,
  output logic        HALTED
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, BRANCH, HALT
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [3:0]  flags;

  logic [3:0]  cond;
  logic [1:0]  op;
  logic        i_bit;
  logic [3:0]  cmd;
  logic        s_bit;
  logic        unused_bits;

  logic [1:0]  cmd_ctl;
  logic        cmd_known;
  logic        cond_ex;

  logic        next_pc_q;
  logic        ir_write_q;
  logic        reg_w_q;
  logic        mem_w_q;
  logic        br_q;
  logic        flag_w_q;
  logic        halted_q;

  assign cond        = INSTRUCTION[31:28];
  assign op          = INSTRUCTION[27:26];
  assign i_bit       = INSTRUCTION[25];
  assign cmd         = INSTRUCTION[24:21];
  assign s_bit       = INSTRUCTION[20];
  assign unused_bits = ^INSTRUCTION[19:0];

  // Map the data-processing command onto an ALU operation; unknown commands add and never write back
  always_comb begin
    cmd_ctl   = 2'b00;
    cmd_known = 1'b1;
    case (cmd)
      4'b0100: cmd_ctl = 2'b00;
      4'b0010: cmd_ctl = 2'b01;
      4'b1010: cmd_ctl = 2'b01;
      4'b0000: cmd_ctl = 2'b10;
      4'b1100: cmd_ctl = 2'b11;
      default: cmd_known = 1'b0;
    endcase
  end

  // Evaluate the condition field against the flags as they stood before this instruction
  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = flags[2];
      4'b0001: cond_ex = ~flags[2];
      4'b0010: cond_ex = flags[1];
      4'b0011: cond_ex = ~flags[1];
      4'b0100: cond_ex = flags[3];
      4'b0101: cond_ex = ~flags[3];
      4'b0110: cond_ex = flags[0];
      4'b0111: cond_ex = ~flags[0];
      4'b1000: cond_ex = flags[1] & ~flags[2];
      4'b1001: cond_ex = ~flags[1] | flags[2];
      4'b1010: cond_ex = (flags[3] == flags[0]);
      4'b1011: cond_ex = (flags[3] != flags[0]);
      4'b1100: cond_ex = ~flags[2] & (flags[3] == flags[0]);
      4'b1101: cond_ex = flags[2] | (flags[3] != flags[0]);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // Choose the successor state from the current state and the instruction fields
  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH:    next_state = DECODE;
      DECODE: begin
        case (op)
          2'b00:   next_state = i_bit ? EXECUTEI : EXECUTER;
          2'b01:   next_state = MEMADR;
          2'b10:   next_state = BRANCH;
          default: next_state = ILLEGAL_TRAP ? HALT : FETCH;
        endcase
      end
      MEMADR:   next_state = s_bit ? MEMREAD : MEMWRITE;
      MEMREAD:  next_state = MEMWB;
      MEMWB:    next_state = FETCH;
      MEMWRITE: next_state = FETCH;
      EXECUTER, EXECUTEI: next_state = (cmd == 4'b1010) ? FETCH : ALUWB;
      ALUWB:    next_state = FETCH;
      BRANCH:   next_state = FETCH;
      HALT:     next_state = HALT;
      default:  next_state = FETCH;
    endcase
  end

  // Advance the state, capture flags at the end of execute, and register the outputs of the state being entered
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= FETCH;
      flags      <= 4'b0000;
      next_pc_q  <= 1'b1;
      ir_write_q <= 1'b1;
      reg_w_q    <= 1'b0;
      mem_w_q    <= 1'b0;
      br_q       <= 1'b0;
      flag_w_q   <= 1'b0;
      halted_q   <= 1'b0;
      AdrSrc     <= 1'b0;
      ResultSrc  <= 2'b10;
      ALUSrcA    <= 1'b1;
      ALUSrcB    <= 2'b10;
      ALUControl <= 2'b00;
    end else begin
      state <= next_state;
      if ((state == EXECUTER || state == EXECUTEI) && flag_w_q && cond_ex)
        flags <= ALU_FLAGS;

      next_pc_q  <= 1'b0;
      ir_write_q <= 1'b0;
      reg_w_q    <= 1'b0;
      mem_w_q    <= 1'b0;
      br_q       <= 1'b0;
      flag_w_q   <= 1'b0;
      halted_q   <= 1'b0;
      AdrSrc     <= 1'b0;
      ResultSrc  <= 2'b00;
      ALUSrcA    <= 1'b0;
      ALUSrcB    <= 2'b00;
      ALUControl <= 2'b00;
      case (next_state)
        FETCH: begin
          next_pc_q  <= 1'b1;
          ir_write_q <= 1'b1;
          ALUSrcA    <= 1'b1;
          ALUSrcB    <= 2'b10;
          ResultSrc  <= 2'b10;
        end
        DECODE: begin
          ALUSrcA   <= 1'b1;
          ALUSrcB   <= 2'b10;
          ResultSrc <= 2'b10;
        end
        EXECUTER: begin
          ALUControl <= cmd_ctl;
          flag_w_q   <= s_bit;
        end
        EXECUTEI: begin
          ALUSrcB    <= 2'b01;
          ALUControl <= cmd_ctl;
          flag_w_q   <= s_bit;
        end
        ALUWB:    reg_w_q <= cmd_known;
        MEMADR:   ALUSrcB <= 2'b01;
        MEMREAD:  AdrSrc  <= 1'b1;
        MEMWB: begin
          ResultSrc <= 2'b01;
          reg_w_q   <= 1'b1;
        end
        MEMWRITE: begin
          AdrSrc  <= 1'b1;
          mem_w_q <= 1'b1;
        end
        BRANCH: begin
          ALUSrcB   <= 2'b01;
          ResultSrc <= 2'b10;
          br_q      <= 1'b1;
        end
        HALT:     halted_q <= 1'b1;
        default:  halted_q <= 1'b0;
      endcase
    end
  end

  assign PCWrite  = RST_N & (next_pc_q | (br_q & cond_ex));
  assign IRWrite  = RST_N & ir_write_q;
  assign RegWrite = RST_N & reg_w_q & cond_ex;
  assign MemWrite = RST_N & mem_w_q & cond_ex;
  assign ILLEGAL  = (state == DECODE) && (op == 2'b11);
  assign HALTED   = halted_q;

endmodule
